fb_write_ctrl: RTL and testbench
================================

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 Parameters: RESOLUTION_H, default 640, visible width in pixels.
REQ-002 Parameters: RESOLUTION_V, default 480, visible height in pixels.
REQ-003 Parameters: HPOS_WIDTH, default 10, x coordinate width.
REQ-004 Parameters: VPOS_WIDTH, default 9, y coordinate width.
REQ-005 Parameters: ADDR_WIDTH, default 19, framebuffer address width; CLEAR_COLOR, default 3'b000, fill colour for clear.
REQ-006 Ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-007 Ports: fifo_empty  in  1  pixel FIFO empty; fifo_rd  out  1  pop strobe; fifo_x  in  HPOS_WIDTH  x; fifo_y  in  VPOS_WIDTH  y; fifo_rgb  in  3  colour.
REQ-008 Ports: blank  in  1  memory write window open (display not reading); clear_req  in  1  single-cycle clear request.
REQ-009 Ports: mem_addr  out  ADDR_WIDTH  write address; mem_wdata  out  3  write data; mem_we  out  1  write enable.
REQ-010 Ports: busy  out  1  clear in progress; drop_cnt  out  16  count of clipped FIFO entries.

Function
REQ-011 FIFO is standard (non-show-ahead): fifo_x/y/rgb valid the cycle after fifo_rd.
REQ-012 State machine SHALL have states IDLE, POP, LATCH, WRITE, CLEAR.
REQ-013 IDLE: clear pending -> CLEAR (priority over FIFO); else blank && !fifo_empty -> POP.
REQ-014 POP: fifo_rd=1 for exactly one cycle -> LATCH; fifo_rd SHALL be 0 in all other states.
REQ-015 LATCH: capture x,y,rgb; compute addr = y*RESOLUTION_H + x, registered, ADDR_WIDTH bits -> WRITE.
REQ-016 WRITE: if x < RESOLUTION_H and y < RESOLUTION_V and blank, assert mem_we one cycle with mem_addr/mem_wdata -> IDLE.
REQ-017 WRITE with out-of-range x or y: no mem_we, drop_cnt += 1 (saturating at 16'hFFFF) -> IDLE.
REQ-018 WRITE with in-range pixel but blank=0: hold in WRITE, mem_we=0, until blank=1; entry never lost.
REQ-019 Peak throughput: one FIFO entry per 4 clocks (IDLE-POP-LATCH-WRITE).
REQ-020 clear_req SHALL set a pending flag in any state; the flag is consumed on entry to CLEAR; clear_req while busy=1 ignored.
REQ-021 CLEAR: sweep address 0..RESOLUTION_H*RESOLUTION_V-1, one write of CLEAR_COLOR per clock while blank=1; when blank=0, mem_we=0 and address holds.
REQ-022 CLEAR: after last address written -> IDLE next cycle; no FIFO pops during CLEAR.
REQ-023 busy=1 exactly while state is CLEAR.
REQ-024 mem_addr, mem_wdata, mem_we, fifo_rd, busy SHALL be registered outputs.
REQ-025 An in-flight FIFO entry (POP/LATCH/WRITE) SHALL complete before a pending clear starts.

Reset
REQ-026 reset asserted: state=IDLE, fifo_rd=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, drop_cnt=0, clear pending flag=0.
REQ-027 reset mid-CLEAR or mid-WRITE SHALL abort immediately with no further mem_we; the popped entry is discarded.
REQ-028 First pop permitted on the first clock edge after reset deasserts with blank=1 and fifo_empty=0.

Verification
REQ-029 blank=1, FIFO holds (x=5,y=2,rgb=3'b101) -> fifo_rd one cycle, then mem_we=1 with mem_addr=1285, mem_wdata=3'b101, 3 cycles after pop.
REQ-030 FIFO holds (x=640,y=10) then (x=0,y=480) -> no mem_we, drop_cnt=2, both entries popped.
REQ-031 In-range entry at WRITE, blank forced low 20 cycles -> mem_we stays 0, asserted on first blank=1 cycle, single write.
REQ-032 clear_req with blank=1 continuously -> busy=1 for 307200 cycles, mem_we each cycle with addresses 0..307199, data CLEAR_COLOR, then busy=0.
REQ-033 clear_req during LATCH with non-empty FIFO -> pending entry written first, then CLEAR; FIFO not popped until busy=0.
REQ-034 reset asserted at clear address 1000 -> mem_we=0 immediately, busy=0, mem_addr=0, drop_cnt=0.

Source files
------------

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl -- framebuffer write controller.
// Drains a standard (non-show-ahead) pixel FIFO into a framebuffer. It writes only while
// the display is not reading (blank=1), clips out-of-range pixels, and performs a
// full-screen clear on request.
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   fifo_empty/fifo_rd FIFO status / pop strobe (data valid the cycle after fifo_rd)
//   fifo_x/y/rgb       popped pixel coordinate and colour
//   blank              framebuffer write window open
//   clear_req          single-cycle clear request
//   mem_addr/wdata/we  framebuffer write port (registered)
//   busy               clear sweep in progress (registered)
//   drop_cnt           saturating count of clipped pixels
module fb_write_ctrl #(
  parameter int         RESOLUTION_H = 640,
  parameter int         RESOLUTION_V = 480,
  parameter int         HPOS_WIDTH   = 10,
  parameter int         VPOS_WIDTH   = 9,
  parameter int         ADDR_WIDTH   = 19,
  parameter logic [2:0] CLEAR_COLOR  = 3'b000
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [HPOS_WIDTH-1:0] fifo_x,
  input  logic [VPOS_WIDTH-1:0] fifo_y,
  input  logic [2:0]            fifo_rgb,
  input  logic                  blank,
  input  logic                  clear_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic [15:0]           drop_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RESOLUTION_H * RESOLUTION_V - 1);

  typedef enum logic [2:0] {IDLE, POP, LATCH, WRITE, CLEAR} state_t;

  state_t                state, state_nx;
  logic                  clr_pend;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_last;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [2:0]            pix_rgb;
  logic                  pix_ok;

  // next values of the registered outputs
  logic                  fifo_rd_d, mem_we_d, busy_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [2:0]            mem_wdata_d;

  assign clr_last = (clr_addr == LAST_ADDR);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clr_pend)                state_nx = CLEAR;  // clear wins over FIFO
               else if (blank && !fifo_empty) state_nx = POP;
      POP:     state_nx = LATCH;
      LATCH:   state_nx = WRITE;
      // clipped pixels leave at once; in-range pixels wait for the write window
      WRITE:   if (!pix_ok || blank)        state_nx = IDLE;
      CLEAR:   if (blank && clr_last)       state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // output logic: computed from the current/next state, registered below
  always_comb begin
    fifo_rd_d   = (state_nx == POP);
    busy_d      = (state_nx == CLEAR);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      WRITE: if (pix_ok && blank) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = pix_addr;
        mem_wdata_d = pix_rgb;
      end
      CLEAR: if (blank) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = clr_addr;
        mem_wdata_d = CLEAR_COLOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_rd   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      drop_cnt  <= '0;
      clr_pend  <= 1'b0;
      clr_addr  <= '0;
      pix_addr  <= '0;
      pix_rgb   <= '0;
      pix_ok    <= 1'b0;
    end else begin
      fifo_rd   <= fifo_rd_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;

      // FIFO data is valid in LATCH (one cycle after the pop)
      if (state == LATCH) begin
        pix_addr <= ADDR_WIDTH'(32'(fifo_y) * 32'(RESOLUTION_H) + 32'(fifo_x));
        pix_rgb  <= fifo_rgb;
        pix_ok   <= (32'(fifo_x) < 32'(RESOLUTION_H)) && (32'(fifo_y) < 32'(RESOLUTION_V));
      end

      if (state == WRITE && !pix_ok && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;

      // a request during a sweep is ignored; entering CLEAR consumes the flag
      if (state != CLEAR && state_nx == CLEAR) clr_pend <= 1'b0;
      else if (clear_req && state != CLEAR)    clr_pend <= 1'b1;

      if (state != CLEAR)           clr_addr <= '0;
      else if (blank && !clr_last)  clr_addr <= clr_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl -- self-checking bench for fb_write_ctrl on a reduced 40x30 screen.
// A behavioural FIFO feeds the DUT; expected framebuffer writes are queued when
// stimulus is driven and compared in order whenever mem_we is seen.
module tb_fb_write_ctrl;
  localparam int         H    = 40;
  localparam int         V    = 30;
  localparam int         HW   = 10;
  localparam int         VW   = 9;
  localparam int         AW   = 19;
  localparam logic [2:0] CC   = 3'b010;
  localparam int         NPIX = H * V;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty, fifo_rd;
  logic [HW-1:0] fifo_x = '0;
  logic [VW-1:0] fifo_y = '0;
  logic [2:0]    fifo_rgb = '0;
  logic          blank = 1'b0;
  logic          clear_req = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_wdata;
  logic          mem_we, busy;
  logic [15:0]   drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  fb_write_ctrl #(
    .RESOLUTION_H(H), .RESOLUTION_V(V), .HPOS_WIDTH(HW), .VPOS_WIDTH(VW),
    .ADDR_WIDTH(AW), .CLEAR_COLOR(CC)
  ) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_x(fifo_x), .fifo_y(fifo_y), .fifo_rgb(fifo_rgb), .blank(blank),
    .clear_req(clear_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .busy(busy), .drop_cnt(drop_cnt)
  );

  // behavioural standard FIFO: data appears the cycle after the pop
  logic [HW+VW+2:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd && rd_ptr != wr_ptr) begin
      {fifo_x, fifo_y, fifo_rgb} <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int x, input int y, input logic [2:0] rgb);
    fmem[wr_ptr] = {HW'(x), VW'(y), rgb};
    wr_ptr++;
  endtask

  task automatic expect_pix(input int x, input int y, input logic [2:0] rgb);
    wr_t e;
    if (x < H && y < V) begin
      e.addr = AW'(y * H + x);
      e.data = rgb;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_clear(input int last);
    wr_t e;
    for (int i = 0; i <= last; i++) begin
      e.addr = AW'(i);
      e.data = CC;
      exp_q.push_back(e);
    end
  endtask

  // write monitor / scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) chk("unexpected_we", 32'(mem_addr), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (busy && fifo_rd) chk("pop_while_busy", 32'(fifo_rd), 32'd0);
  end

  initial begin
    bit ok;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_fifo_rd",  32'(fifo_rd),   32'd0);
    chk("rst_mem_we",   32'(mem_we),    32'd0);
    chk("rst_mem_addr", 32'(mem_addr),  32'd0);
    chk("rst_wdata",    32'(mem_wdata), 32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_drop",     32'(drop_cnt),  32'd0);

    // first pop right after reset release; write lands 3 cycles after the pop
    push(5, 2, 3'b101); expect_pix(5, 2, 3'b101);
    blank = 1'b1;
    reset = 1'b0;
    @(negedge clk); chk("first_pop",     32'(fifo_rd), 32'd1);
    @(negedge clk); chk("pop_one_cycle", 32'(fifo_rd), 32'd0);
    @(negedge clk); chk("we_lat2",       32'(mem_we),  32'd0);
    @(negedge clk); chk("we_lat3",       32'(mem_we),  32'd1);
    @(negedge clk); chk("we_single",     32'(mem_we),  32'd0);

    // clipping: two out-of-range entries, then the bottom-right corner pixel
    push(640, 10, 3'b001);
    push(0, 30, 3'b011);
    push(39, 29, 3'b110); expect_pix(39, 29, 3'b110);
    repeat (20) @(negedge clk);
    chk("drop_cnt2",    32'(drop_cnt), 32'd2);
    chk("drop_popped",  32'(rd_ptr),   32'(wr_ptr));
    chk("drop_sb_done", 32'(exp_q.size()), 32'd0);

    // write window closes while the pixel is in flight: held, not lost
    push(7, 3, 3'b011); expect_pix(7, 3, 3'b011);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); if (fifo_rd) ok = 1; end
    chk("stall_pop_seen", 32'(ok), 32'd1);
    blank = 1'b0;
    n = 0;
    repeat (20) begin @(negedge clk); if (mem_we) n++; end
    chk("stall_no_we", 32'(n), 32'd0);
    blank = 1'b1;
    @(negedge clk); chk("stall_we",     32'(mem_we), 32'd1);
    @(negedge clk); chk("stall_single", 32'(mem_we), 32'd0);

    // clear requested during LATCH: in-flight pixel first, then sweep, then next entry
    push(1, 1, 3'b001); push(2, 2, 3'b100);
    expect_pix(1, 1, 3'b001);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); if (fifo_rd) ok = 1; end
    chk("clr_pop_seen", 32'(ok), 32'd1);
    @(negedge clk);
    clear_req = 1'b1;
    expect_clear(NPIX - 1);
    expect_pix(2, 2, 3'b100);
    @(negedge clk); clear_req = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin if (busy) ok = 1; else @(negedge clk); end
    chk("clr_busy_start", 32'(ok), 32'd1);
    chk("clr_fifo_held",  32'(wr_ptr - rd_ptr), 32'd1);
    // 5-cycle blank gap mid-sweep and an ignored re-request while busy
    n = 0;
    while (busy && n < NPIX + 50) begin
      n++;
      clear_req = (n == 100);
      blank = !(n >= 500 && n < 505);
      @(negedge clk);
    end
    clear_req = 1'b0;
    blank = 1'b1;
    chk("busy_len", 32'(n), 32'(NPIX + 5));
    repeat (15) @(negedge clk);
    chk("clr_sb_done",   32'(exp_q.size()), 32'd0);
    chk("clr_fifo_done", 32'(rd_ptr), 32'(wr_ptr));
    chk("clr_idle_busy", 32'(busy), 32'd0);

    // reset while the sweep is at address 1000
    clear_req = 1'b1;
    expect_clear(1000);
    @(negedge clk); clear_req = 1'b0;
    ok = 0;
    for (int i = 0; i < 1100 && !ok; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == AW'(1000)) ok = 1;
    end
    chk("clr_reach_1000", 32'(ok), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_we",   32'(mem_we),   32'd0);
    chk("rst_mid_busy", 32'(busy),     32'd0);
    chk("rst_mid_addr", 32'(mem_addr), 32'd0);
    chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_sb",   32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
